// File: rtl/chunked_addsub_pkg.sv
// Shared definitions for the chunked add/subtract unit: FSM state encodings
// kept as plain constants so legacy code that compares raw state values still works.
package chunked_addsub_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/chunked_addsub_if.sv
// Operand/result handshake bundle for chunked_addsub; the producer/consumer
// side uses the master modport, the arithmetic unit uses the slave modport.
interface chunked_addsub_if #(
  parameter int WIDTH = 32
);

  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_a;
  logic [WIDTH-1:0] io_in_b;
  logic             io_in_sub;
  logic             io_in_cin;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_out_s;
  logic             io_out_c;
  logic             io_out_ovf;

  modport master (
    output io_in_valid,
    input  io_in_ready,
    output io_in_a,
    output io_in_b,
    output io_in_sub,
    output io_in_cin,
    input  io_out_valid,
    output io_out_ready,
    input  io_out_s,
    input  io_out_c,
    input  io_out_ovf
  );

  modport slave (
    input  io_in_valid,
    output io_in_ready,
    input  io_in_a,
    input  io_in_b,
    input  io_in_sub,
    input  io_in_cin,
    output io_out_valid,
    input  io_out_ready,
    output io_out_s,
    output io_out_c,
    output io_out_ovf
  );

endinterface

// File: rtl/chunked_addsub_chunk_add_slice.sv
// Combinational CHUNK-bit adder with carry-in and carry-out; the only
// arithmetic on the critical path of chunked_addsub.
module chunk_add_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    s    = full[CHUNK-1:0];
    co   = full[CHUNK];
  end

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per cycle with the carry
// chained through a register; valid/ready on both operand and result sides.
module chunked_addsub
  import chunked_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  chunked_addsub_if.slave  io
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  logic [STATE_W-1:0] state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   res_next;
  logic [WIDTH-1:0]   s_q;
  logic               carry_q;
  logic               c_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK-1:0]   sum_chunk;
  logic               carry_out;
  logic               last_chunk;
  logic               ovf_next;

  always_comb begin
    a_chunk    = a_q[int'(cnt_q)*CHUNK +: CHUNK];
    b_chunk    = b_q[int'(cnt_q)*CHUNK +: CHUNK];
    last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));
    res_next   = res_q;
    res_next[int'(cnt_q)*CHUNK +: CHUNK] = sum_chunk;
    // B is already inverted for subtraction, so the add-rule overflow test covers both
    ovf_next   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_chunk[CHUNK-1] != a_q[WIDTH-1]);
  end

  chunk_add_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a  (a_chunk),
    .b  (b_chunk),
    .ci (carry_q),
    .s  (sum_chunk),
    .co (carry_out)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io.io_in_valid) begin
            a_q     <= io.io_in_a;
            b_q     <= io.io_in_sub ? ~io.io_in_b : io.io_in_b;
            carry_q <= io.io_in_sub ? ~io.io_in_cin : io.io_in_cin;
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_q   <= res_next;
          carry_q <= carry_out;
          if (last_chunk) begin
            // Visible outputs only change here, so they stay put during the next RUN
            s_q     <= res_next;
            c_q     <= carry_out;
            ovf_q   <= ovf_next;
            cnt_q   <= '0;
            state_q <= ST_DONE;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (io.io_out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    io.io_in_ready  = (state_q == ST_IDLE);
    io.io_out_valid = (state_q == ST_DONE);
    io.io_out_s     = s_q;
    io.io_out_c     = c_q;
    io.io_out_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_chunked_addsub.sv
// Randomised self-checking bench for chunked_addsub against a signed/unsigned
// arithmetic reference model; also covers a single-chunk WIDTH=8 instance.
module tb_chunked_addsub;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  chunked_addsub_if #(.WIDTH(32)) bus  ();
  chunked_addsub_if #(.WIDTH(8))  bus8 ();

  chunked_addsub #(.WIDTH(32), .CHUNK(8)) dut (
    .clock (clk),
    .reset (reset),
    .io    (bus)
  );

  chunked_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clock (clk),
    .reset (reset),
    .io    (bus8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned arithmetic for sum/carry, signed range test for overflow
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic sub, input logic cin,
                                output logic [31:0] s, output logic c, output logic ovf);
    longint unsigned ua, ub, full;
    longint          sa, sb, r;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!sub) begin
      full = ua + ub + longint'(cin);
      c    = full[32];
      r    = sa + sb + longint'(cin);
    end else begin
      full = ua - ub - longint'(cin);
      c    = (ua >= ub + longint'(cin));
      r    = sa - sb - longint'(cin);
    end
    s   = full[31:0];
    ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic cin,
                       input int hold, input bit pulse);
    logic [31:0] es;
    logic        ec, eo;
    int          lat;
    model(a, b, sub, cin, es, ec, eo);
    @(negedge clk);
    check("in_ready_idle", bus.io_in_ready, 1);
    bus.io_in_valid = 1'b1;
    bus.io_in_a     = a;
    bus.io_in_b     = b;
    bus.io_in_sub   = sub;
    bus.io_in_cin   = cin;
    @(posedge clk);
    #1;
    bus.io_in_valid = 1'b0;
    bus.io_in_a     = $urandom;
    bus.io_in_b     = $urandom;
    bus.io_in_sub   = 1'($urandom);
    bus.io_in_cin   = 1'($urandom);
    lat = 0;
    while (!bus.io_out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 4);
    check("s", bus.io_out_s, es);
    check("c", bus.io_out_c, ec);
    check("ovf", bus.io_out_ovf, eo);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (pulse) begin
        bus.io_in_valid = 1'b1;
        bus.io_in_a     = 32'h1111_1111;
        bus.io_in_b     = 32'h2222_2222;
      end
      @(posedge clk);
      #1;
      bus.io_in_valid = 1'b0;
      check("hold_valid", bus.io_out_valid, 1);
      check("hold_in_ready", bus.io_in_ready, 0);
      check("hold_s", bus.io_out_s, es);
      check("hold_c", bus.io_out_c, ec);
      check("hold_ovf", bus.io_out_ovf, eo);
    end
    @(negedge clk);
    bus.io_out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.io_out_ready = 1'b0;
    check("after_hs_valid", bus.io_out_valid, 0);
    check("after_hs_s", bus.io_out_s, es);
  endtask

  initial begin
    int lat8;
    bus.io_in_valid  = 1'b0;
    bus.io_in_a      = '0;
    bus.io_in_b      = '0;
    bus.io_in_sub    = 1'b0;
    bus.io_in_cin    = 1'b0;
    bus.io_out_ready = 1'b0;
    bus8.io_in_valid  = 1'b0;
    bus8.io_in_a      = '0;
    bus8.io_in_b      = '0;
    bus8.io_in_sub    = 1'b0;
    bus8.io_in_cin    = 1'b0;
    bus8.io_out_ready = 1'b0;

    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.io_in_ready, 1);
    check("rst_out_valid", bus.io_out_valid, 0);
    check("rst_s", bus.io_out_s, 0);
    check("rst_c", bus.io_out_c, 0);
    check("rst_ovf", bus.io_out_ovf, 0);
    @(negedge clk);
    reset = 1'b0;

    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
    do_op(32'd5,         32'd7,         1'b1, 1'b0, 0, 1'b0);
    do_op(32'h8000_0000, 32'd1,         1'b1, 1'b0, 0, 1'b0);
    do_op(32'd10,        32'd3,         1'b1, 1'b1, 0, 1'b0);
    do_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1, 3, 1'b1);

    // Reset two cycles into RUN; outputs currently hold a non-zero result
    @(negedge clk);
    bus.io_in_valid = 1'b1;
    bus.io_in_a     = 32'hDEAD_BEEF;
    bus.io_in_b     = 32'h0BAD_F00D;
    bus.io_in_sub   = 1'b0;
    bus.io_in_cin   = 1'b0;
    @(posedge clk);
    #1 bus.io_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrun_in_ready", bus.io_in_ready, 1);
    check("midrun_out_valid", bus.io_out_valid, 0);
    check("midrun_s", bus.io_out_s, 0);
    check("midrun_c", bus.io_out_c, 0);
    check("midrun_ovf", bus.io_out_ovf, 0);
    @(negedge clk);
    reset = 1'b0;
    do_op(32'd3, 32'd4, 1'b0, 1'b0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (n % 4 == 0) ra = {ra[31], 31'h7FFF_FFFF} ^ 32'h0000_00FF;
      do_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    // Single-chunk instance: RUN lasts one cycle
    @(negedge clk);
    check("w8_in_ready", bus8.io_in_ready, 1);
    bus8.io_in_valid = 1'b1;
    bus8.io_in_a     = 8'hC8;
    bus8.io_in_b     = 8'h64;
    bus8.io_in_sub   = 1'b0;
    bus8.io_in_cin   = 1'b0;
    @(posedge clk);
    #1 bus8.io_in_valid = 1'b0;
    lat8 = 0;
    while (!bus8.io_out_valid && lat8 < 20) begin
      @(posedge clk);
      #1;
      lat8++;
    end
    check("w8_latency", lat8, 1);
    check("w8_s", bus8.io_out_s, 8'h2C);
    check("w8_c", bus8.io_out_c, 1);
    check("w8_ovf", bus8.io_out_ovf, 0);
    @(negedge clk);
    bus8.io_out_ready = 1'b1;
    @(posedge clk);
    #1 bus8.io_out_ready = 1'b0;
    check("w8_after_hs_valid", bus8.io_out_valid, 0);
    check("w8_after_hs_in_ready", bus8.io_in_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
